// File: rtl/qif_spike_monitor.sv
// Reduces the QIF neuron spike train and membrane potential to per-window
// spike rate, per-window peak potential and the last inter-spike interval.
module qif_spike_monitor #(
    parameter int WINDOW_LOG2 = 10,
    parameter int CNT_W       = 8,
    parameter int ISI_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             spike_in,
    input  logic [7:0]       v_in,
    output logic [CNT_W-1:0] rate,
    output logic [7:0]       peak_v,
    output logic             window_done,
    output logic [ISI_W-1:0] isi,
    output logic             isi_valid,
    output logic             isi_ovf
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_TIMING = 2'd1;
    localparam logic [1:0] ST_SAT    = 2'd2;

    localparam logic [CNT_W-1:0]       CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [ISI_W-1:0]       ISI_MAX  = {ISI_W{1'b1}};
    localparam logic [ISI_W-1:0]       ISI_ONE  = {{(ISI_W-1){1'b0}}, 1'b1};
    localparam logic [WINDOW_LOG2-1:0] WIN_ONE  = {{(WINDOW_LOG2-1){1'b0}}, 1'b1};

    logic                   spike_q_r;
    logic [WINDOW_LOG2-1:0] win_cnt_r;
    logic [CNT_W-1:0]       acc_r;
    logic [7:0]             peak_acc_r;
    logic [CNT_W-1:0]       rate_r;
    logic [7:0]             peak_v_r;
    logic                   window_done_r;
    logic [1:0]             state_r;
    logic [ISI_W-1:0]       isi_cnt_r;
    logic [ISI_W-1:0]       isi_r;
    logic                   isi_valid_r;
    logic                   isi_ovf_r;

    logic                   edge_s;
    logic                   last_cycle_s;
    logic [CNT_W-1:0]       acc_sum_s;
    logic [7:0]             peak_max_s;
    logic [1:0]             state_nxt_s;
    logic [ISI_W-1:0]       isi_cnt_nxt_s;
    logic [ISI_W-1:0]       isi_nxt_s;
    logic                   isi_valid_nxt_s;
    logic                   isi_ovf_nxt_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a, input logic b);
        if (a == CNT_MAX) begin
            sat_inc = CNT_MAX;
        end else begin
            sat_inc = a + {{(CNT_W-1){1'b0}}, b};
        end
    endfunction

    assign edge_s       = spike_in & ~spike_q_r;
    assign last_cycle_s = &win_cnt_r;
    assign acc_sum_s    = sat_inc(acc_r, edge_s);
    assign peak_max_s   = (v_in > peak_acc_r) ? v_in : peak_acc_r;

    // Spike edge detector delay stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_q_r <= 1'b0;
        end else if (ena) begin
            spike_q_r <= spike_in;
        end
    end

    // Window accumulator; an edge on the closing cycle belongs to the closing window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_r     <= '0;
            acc_r         <= '0;
            peak_acc_r    <= 8'd0;
            rate_r        <= '0;
            peak_v_r      <= 8'd0;
            window_done_r <= 1'b0;
        end else if (ena) begin
            win_cnt_r <= win_cnt_r + WIN_ONE;
            if (last_cycle_s) begin
                rate_r        <= acc_sum_s;
                peak_v_r      <= peak_max_s;
                window_done_r <= 1'b1;
                acc_r         <= '0;
                peak_acc_r    <= 8'd0;
            end else begin
                acc_r         <= acc_sum_s;
                peak_acc_r    <= peak_max_s;
                window_done_r <= 1'b0;
            end
        end
    end

    // ISI next-state: the counter holds at max once an interval has overflowed
    always_comb begin
        state_nxt_s     = state_r;
        isi_cnt_nxt_s   = isi_cnt_r;
        isi_nxt_s       = isi_r;
        isi_ovf_nxt_s   = isi_ovf_r;
        isi_valid_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (edge_s) begin
                    isi_cnt_nxt_s = ISI_ONE;
                    state_nxt_s   = ST_TIMING;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_TIMING: begin
                if (edge_s) begin
                    isi_nxt_s       = isi_cnt_r;
                    isi_ovf_nxt_s   = 1'b0;
                    isi_valid_nxt_s = 1'b1;
                    isi_cnt_nxt_s   = ISI_ONE;
                end else if (isi_cnt_r == ISI_MAX) begin
                    state_nxt_s     = ST_SAT;
                end else begin
                    isi_cnt_nxt_s   = isi_cnt_r + ISI_ONE;
                end
            end
            ST_SAT: begin
                if (edge_s) begin
                    isi_nxt_s       = ISI_MAX;
                    isi_ovf_nxt_s   = 1'b1;
                    isi_valid_nxt_s = 1'b1;
                    isi_cnt_nxt_s   = ISI_ONE;
                    state_nxt_s     = ST_TIMING;
                end else begin
                    state_nxt_s     = ST_SAT;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                isi_cnt_nxt_s = '0;
            end
        endcase
    end

    // ISI state and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            isi_cnt_r   <= '0;
            isi_r       <= '0;
            isi_valid_r <= 1'b0;
            isi_ovf_r   <= 1'b0;
        end else if (ena) begin
            state_r     <= state_nxt_s;
            isi_cnt_r   <= isi_cnt_nxt_s;
            isi_r       <= isi_nxt_s;
            isi_valid_r <= isi_valid_nxt_s;
            isi_ovf_r   <= isi_ovf_nxt_s;
        end
    end

    assign rate        = rate_r;
    assign peak_v      = peak_v_r;
    assign window_done = window_done_r;
    assign isi         = isi_r;
    assign isi_valid   = isi_valid_r;
    assign isi_ovf     = isi_ovf_r;

endmodule

// File: tb/tb_qif_spike_monitor.sv
// Bench for qif_spike_monitor: directed scenarios plus random traffic, compared
// each cycle against a cycle-index based reference model.
module tb_qif_spike_monitor;

    localparam int WL   = 4;
    localparam int CW   = 3;
    localparam int IW   = 4;
    localparam int WIN  = 16;
    localparam int RMAX = 7;
    localparam int IMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          spike_in;
    logic [7:0]    v_in;
    logic [CW-1:0] rate;
    logic [7:0]    peak_v;
    logic          window_done;
    logic [IW-1:0] isi;
    logic          isi_valid;
    logic          isi_ovf;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state: enabled-cycle index since reset and event bookkeeping
    int            m_n;
    int            m_last;
    int            m_cnt;
    int            m_max;
    bit            m_prev;
    logic [CW-1:0] exp_rate;
    logic [7:0]    exp_peak;
    logic          exp_wd;
    logic [IW-1:0] exp_isi;
    logic          exp_iv;
    logic          exp_ovf;

    qif_spike_monitor #(.WINDOW_LOG2(WL), .CNT_W(CW), .ISI_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in), .v_in(v_in),
        .rate(rate), .peak_v(peak_v), .window_done(window_done),
        .isi(isi), .isi_valid(isi_valid), .isi_ovf(isi_ovf)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_n = 0; m_last = -1; m_cnt = 0; m_max = 0; m_prev = 1'b0;
        exp_rate = '0; exp_peak = 8'd0; exp_wd = 1'b0;
        exp_isi = '0; exp_iv = 1'b0; exp_ovf = 1'b0;
    endtask

    // One clock: drive inputs at negedge, advance the model at posedge, return #1 later
    task automatic step(input bit rst, input bit en, input bit sp, input logic [7:0] v);
        int  d;
        bit  e;
        @(negedge clk);
        rst_n = rst; ena = en; spike_in = sp; v_in = v;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (en) begin
            e = sp && !m_prev;
            m_prev = sp;
            exp_wd = 1'b0;
            exp_iv = 1'b0;
            if (e) begin
                if (m_last >= 0) begin
                    d       = m_n - m_last;
                    exp_isi = IW'((d > IMAX) ? IMAX : d);
                    exp_ovf = (d > IMAX);
                    exp_iv  = 1'b1;
                end
                m_last = m_n;
                m_cnt++;
            end
            if (int'(v) > m_max) m_max = int'(v);
            if (m_n % WIN == WIN - 1) begin
                exp_rate = CW'((m_cnt > RMAX) ? RMAX : m_cnt);
                exp_peak = 8'(m_max);
                exp_wd   = 1'b1;
                m_cnt    = 0;
                m_max    = 0;
            end
            m_n++;
        end
        #1;
    endtask

    task automatic align_window();
        while (m_n % WIN != 0) step(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
    endtask

    task automatic test_reset();
        int cycles = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, i[0], 8'($urandom_range(0, 255)));
            vectors++;
            if ({rate, peak_v, window_done, isi, isi_valid, isi_ovf} !== '0) begin
                miscompares++;
                $display("FAIL reset: outputs=%h required 0", {rate, peak_v, window_done, isi, isi_valid, isi_ovf});
            end
        end
        do begin
            step(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
            cycles++;
        end while (!window_done && cycles < 40);
        vectors++;
        if (cycles != WIN) begin
            miscompares++;
            $display("FAIL first_window: window_done after %0d cycles required %0d", cycles, WIN);
        end
    endtask

    task automatic test_rate();
        align_window();
        for (int i = 0; i < 48; i++) begin
            step(1'b1, 1'b1, (i < 32) ? (i % 4 == 0) : (i - 32 < 10), 8'($urandom_range(0, 255)));
            vectors++;
            if ({rate, peak_v, window_done, isi, isi_valid, isi_ovf} !==
                {exp_rate, exp_peak, exp_wd, exp_isi, exp_iv, exp_ovf}) begin
                miscompares++;
                $display("FAIL rate_model i=%0d: got rate=%0d peak=%0d wd=%b isi=%0d iv=%b ovf=%b required rate=%0d peak=%0d wd=%b isi=%0d iv=%b ovf=%b",
                         i, rate, peak_v, window_done, isi, isi_valid, isi_ovf, exp_rate, exp_peak, exp_wd, exp_isi, exp_iv, exp_ovf);
            end
            if (i == 15 || i == 31 || i == 47) begin
                vectors++;
                if (!window_done || rate !== ((i == 47) ? 3'd1 : 3'd4)) begin
                    miscompares++;
                    $display("FAIL rate_value i=%0d: got wd=%b rate=%0d required wd=1 rate=%0d", i, window_done, rate, (i == 47) ? 1 : 4);
                end
            end
        end
    endtask

    task automatic test_isi();
        step(1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 26; i++) begin
            step(1'b1, 1'b1, (i == 5 || i == 12 || i == 20), 8'($urandom_range(0, 255)));
            vectors++;
            if ({rate, peak_v, window_done, isi, isi_valid, isi_ovf} !==
                {exp_rate, exp_peak, exp_wd, exp_isi, exp_iv, exp_ovf}) begin
                miscompares++;
                $display("FAIL isi_model i=%0d: got isi=%0d iv=%b ovf=%b required isi=%0d iv=%b ovf=%b",
                         i, isi, isi_valid, isi_ovf, exp_isi, exp_iv, exp_ovf);
            end
            if (i == 5 || i == 12 || i == 20) begin
                vectors++;
                if ({isi_valid, isi, isi_ovf} !== ((i == 5) ? {1'b0, 4'd0, 1'b0} :
                                                   (i == 12) ? {1'b1, 4'd7, 1'b0} : {1'b1, 4'd8, 1'b0})) begin
                    miscompares++;
                    $display("FAIL isi_value i=%0d: got iv=%b isi=%0d ovf=%b", i, isi_valid, isi, isi_ovf);
                end
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, (i == 0 || i == 30 || i == 33), 8'($urandom_range(0, 255)));
            vectors++;
            if ({rate, peak_v, window_done, isi, isi_valid, isi_ovf} !==
                {exp_rate, exp_peak, exp_wd, exp_isi, exp_iv, exp_ovf}) begin
                miscompares++;
                $display("FAIL sat_model i=%0d: got isi=%0d iv=%b ovf=%b rate=%0d required isi=%0d iv=%b ovf=%b rate=%0d",
                         i, isi, isi_valid, isi_ovf, rate, exp_isi, exp_iv, exp_ovf, exp_rate);
            end
            if (i == 30 || i == 33) begin
                vectors++;
                if ({isi_valid, isi, isi_ovf} !== ((i == 30) ? {1'b1, 4'd15, 1'b1} : {1'b1, 4'd3, 1'b0})) begin
                    miscompares++;
                    $display("FAIL isi_sat i=%0d: got iv=%b isi=%0d ovf=%b", i, isi_valid, isi, isi_ovf);
                end
            end
        end
        align_window();
        for (int i = 0; i < WIN; i++) step(1'b1, 1'b1, (i % 2 == 0), 8'd0);
        vectors++;
        if (!window_done || rate !== 3'd7) begin
            miscompares++;
            $display("FAIL rate_sat: got wd=%b rate=%0d required wd=1 rate=7", window_done, rate);
        end
    endtask

    task automatic test_boundary();
        align_window();
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b1, (i == 15), (i <= 8) ? 8'(i * 25) : 8'd10);
            vectors++;
            if ({rate, peak_v, window_done, isi, isi_valid, isi_ovf} !==
                {exp_rate, exp_peak, exp_wd, exp_isi, exp_iv, exp_ovf}) begin
                miscompares++;
                $display("FAIL bound_model i=%0d: got rate=%0d peak=%0d wd=%b required rate=%0d peak=%0d wd=%b",
                         i, rate, peak_v, window_done, exp_rate, exp_peak, exp_wd);
            end
            if (i == 15 || i == 31) begin
                vectors++;
                if ({window_done, rate, peak_v} !== ((i == 15) ? {1'b1, 3'd1, 8'd200} : {1'b1, 3'd0, 8'd10})) begin
                    miscompares++;
                    $display("FAIL bound_value i=%0d: got wd=%b rate=%0d peak=%0d", i, window_done, rate, peak_v);
                end
            end
        end
    endtask

    task automatic test_ena();
        int wd_seen = 0;
        align_window();
        for (int i = 0; i < 21; i++) begin
            step(1'b1, !(i >= 4 && i <= 8), (i == 0 || i == 12), 8'($urandom_range(0, 255)));
            vectors++;
            if ({rate, peak_v, window_done, isi, isi_valid, isi_ovf} !==
                {exp_rate, exp_peak, exp_wd, exp_isi, exp_iv, exp_ovf}) begin
                miscompares++;
                $display("FAIL ena_model i=%0d: got isi=%0d iv=%b wd=%b required isi=%0d iv=%b wd=%b",
                         i, isi, isi_valid, window_done, exp_isi, exp_iv, exp_wd);
            end
            if (window_done && wd_seen == 0) wd_seen = i;
        end
        vectors++;
        if (wd_seen != 20) begin
            miscompares++;
            $display("FAIL ena_window: window_done at i=%0d required 20", wd_seen);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 14; i++) begin
            step(i != 6, 1'b1, (i == 2 || i == 10), 8'($urandom_range(0, 255)));
            vectors++;
            if ({rate, peak_v, window_done, isi, isi_valid, isi_ovf} !==
                {exp_rate, exp_peak, exp_wd, exp_isi, exp_iv, exp_ovf}) begin
                miscompares++;
                $display("FAIL midrst_model i=%0d: got isi=%0d iv=%b rate=%0d required isi=%0d iv=%b rate=%0d",
                         i, isi, isi_valid, rate, exp_isi, exp_iv, exp_rate);
            end
            if (i == 10) begin
                vectors++;
                if (isi_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL midrst_isi: got isi_valid=%b required 0", isi_valid);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 499) != 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)));
            vectors++;
            if ({rate, peak_v, window_done, isi, isi_valid, isi_ovf} !==
                {exp_rate, exp_peak, exp_wd, exp_isi, exp_iv, exp_ovf}) begin
                miscompares++;
                $display("FAIL random i=%0d: got rate=%0d peak=%0d wd=%b isi=%0d iv=%b ovf=%b required rate=%0d peak=%0d wd=%b isi=%0d iv=%b ovf=%b",
                         i, rate, peak_v, window_done, isi, isi_valid, isi_ovf, exp_rate, exp_peak, exp_wd, exp_isi, exp_iv, exp_ovf);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; spike_in = 1'b0; v_in = 8'd0;
        model_reset();
        test_reset();
        test_rate();
        test_isi();
        test_saturation();
        test_boundary();
        test_ena();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
